muldiv_hilo_ctrl: RTL and testbench
===================================

# muldiv_hilo_ctrl

Sequencer for the HI/LO register file in the MIPS core. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from the execute stage and runs a 1-cycle multiply or a 32-iteration radix-2 restoring divide. While the operation is in flight it stalls the pipeline. On completion it issues a single write pulse carrying the HI/LO values to the HI/LO register.

## Interface
- No parameters; datapath width fixed at 32.
- clk  in  1  core clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- op_valid  in  1  E-stage holds a HI/LO-class instruction
- op  in  3  000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, 11x reserved
- src_a  in  32  rs operand / dividend / MTHI-MTLO data
- src_b  in  32  rt operand / divisor
- hi_cur, lo_cur  in  32 each  current HI/LO register contents
- flush  in  1  exception/flush of E stage
- stall  out  1  hold IF/ID/E (combinational)
- busy  out  1  state != IDLE
- hilo_we  out  1  one-cycle write strobe to HI/LO register
- hi_o, lo_o  out  32 each  write data, valid when hilo_we=1

## Operation
- States are IDLE, MUL, DIV, DONE.
- **Reset values:** state=IDLE, stall=0, busy=0, hilo_we=0, hi_o=lo_o=0, iteration counter=0.
- **IDLE, op_valid=1, flush=0:**
  - MULT/MULTU: latch operands, go to MUL, stall=1.
  - DIV/DIVU with src_b≠0: latch |src_a| and |src_b| (DIVU: raw values), clear remainder, counter=0, record quotient and remainder signs, go to DIV, stall=1.
  - DIV/DIVU with src_b=0: stall=1, go to DONE with lo_o=FFFFFFFF and hi_o=src_a.
  - MTHI: stay IDLE, stall=0. Next cycle hilo_we=1, hi_o=src_a, lo_o=lo_cur.
  - MTLO: stay IDLE, stall=0. Next cycle hilo_we=1, hi_o=hi_cur, lo_o=src_a.
  - Reserved op: ignored; no stall, no write.
- **MUL:** 64-bit product (signed for MULT, unsigned for MULTU) goes into {hi_o, lo_o`}`; then DONE. stall=1.
- **DIV:** one restoring step per cycle (shift remainder, trial-subtract, set quotient bit). After iteration 31 (counter=31), apply signs and go to DONE. stall=1.
  - Signed quotient is negated when operand signs differ.
  - Signed remainder takes the sign of the dividend.
  - 0x80000000 / FFFFFFFF gives q=0x80000000, r=0; no trap.
- **DONE:** hilo_we=1, stall=0; always returns to IDLE. The instruction leaves E this cycle; no op is accepted in DONE.
- **flush=1 in any state:**
  - stall=0 that cycle.
  - hilo_we is forced to 0 that cycle (combinational gate).
  - Next state is IDLE, any pending MTHI/MTLO write is cancelled, and no op is accepted.
- rst asserted mid-operation aborts immediately to the reset values; no write occurs.
- **Handshake:** E must hold op, src_a and src_b stable while stall=1. Operands are sampled only on the accepting IDLE cycle.

## Timing
- Cycle 0 is the IDLE acceptance cycle.
- **MULT/MULTU:** stall high in cycles 0–1; MUL in cycle 1; hilo_we in cycle 2. Total 3 cycles, 2 stall cycles.
- **DIV/DIVU:** stall high in cycles 0–32; DIV in cycles 1–32; hilo_we in cycle 33.
- **Divide by zero:** stall in cycle 0; hilo_we in cycle 1.
- **MTHI/MTLO:** no stall; hilo_we in cycle 1.
  - An op accepted in cycle 1 is independent of that write.
  - HI/LO forwarding to MFHI/MFLO belongs to the datapath, not this block.
- hi_o, lo_o and hilo_we are registered. The only combinational path is the flush gate.
- stall is combinational from state, op_valid, op and flush.

## Test plan
- Reset released, MULT src_a=FFFFFFFF src_b=00000002 -> stall high 2 cycles, cycle 2 hilo_we=1, hi_o=FFFFFFFF, lo_o=FFFFFFFE. Same operands with MULTU -> hi_o=00000001, lo_o=FFFFFFFE.
- DIVU 7/2 -> 33 stall cycles, lo_o=00000003, hi_o=00000001. DIV FFFFFFF9/00000002 -> lo_o=FFFFFFFD, hi_o=FFFFFFFF. DIV 80000000/FFFFFFFF -> lo_o=80000000, hi_o=00000000.
- DIV 12345678/0 -> stall 1 cycle, next cycle hilo_we=1, lo_o=FFFFFFFF, hi_o=12345678.
- MTHI A5A5A5A5 with hi_cur=0, lo_cur=11111111, followed next cycle by MULT -> cycle 1 hilo_we=1, hi_o=A5A5A5A5, lo_o=11111111. MULT is accepted in cycle 1 and its result written in cycle 3.
- DIV started, flush at cycle 10 -> stall=0 that cycle, IDLE next cycle, no hilo_we ever. A MULT issued afterwards completes normally.
- rst pulsed mid-DIV (cycle 5, asynchronous, between edges) -> outputs go to reset values immediately, busy=0, no write. Flush coincident with a DONE cycle -> hilo_we stays 0.

Source files
------------

// File: rtl/muldiv_hilo_ctrl.sv
// muldiv_hilo_ctrl
//   Sequencer for the HI/LO register file. Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO
//   from the execute stage. It performs a 1-cycle multiply or a 32-iteration
//   radix-2 restoring divide, and stalls the pipeline while the operation runs.
//   When the operation completes it issues one registered write pulse that
//   carries the new HI/LO values.
//
// Ports
//   clk, rst        core clock (rising edge), asynchronous active-high reset
//   op_valid        E stage holds a HI/LO-class instruction
//   op[2:0]         000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO
//   src_a, src_b    rs / rt operands (dividend / divisor, MTHI/MTLO data in src_a)
//   hi_cur, lo_cur  current HI/LO contents (the half that MTHI/MTLO leaves unchanged)
//   flush           E-stage flush: kills the in-flight op and gates hilo_we
//   stall           hold IF/ID/E (combinational)
//   busy            sequencer not idle
//   hilo_we         one-cycle HI/LO write strobe
//   hi_o, lo_o      write data, valid while hilo_we=1
module muldiv_hilo_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic        op_valid,
    input  logic [2:0]  op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic [31:0] hi_cur,
    input  logic [31:0] lo_cur,
    input  logic        flush,
    output logic        stall,
    output logic        busy,
    output logic        hilo_we,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    state_t      state_q, state_d;
    logic [31:0] a_q, a_d;        // multiplicand, or dividend shifting into quotient
    logic [31:0] b_q, b_d;        // multiplier or divisor magnitude
    logic [31:0] rem_q, rem_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        msgn_q, msgn_d;  // signed multiply
    logic        qneg_q, qneg_d;  // negate quotient at the end
    logic        rneg_q, rneg_d;  // negate remainder at the end
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic        we_q, we_d;

    // Operand decode for the accepting cycle
    logic        is_mul, is_div, op_signed, a_neg, b_neg;
    logic [31:0] a_abs, b_abs;

    assign is_mul    = (op == OP_MULT) || (op == OP_MULTU);
    assign is_div    = (op == OP_DIV)  || (op == OP_DIVU);
    assign op_signed = ~op[0];
    assign a_neg     = op_signed & src_a[31];
    assign b_neg     = op_signed & src_b[31];
    assign a_abs     = a_neg ? (32'd0 - src_a) : src_a;
    assign b_abs     = b_neg ? (32'd0 - src_b) : src_b;

    // Multiply: sign- or zero-extend both operands to 64 bits. The low 64 bits
    // of the product are then correct for both the signed and unsigned cases.
    logic signed [63:0] mul_a, mul_b, prod;
    assign mul_a = {{32{msgn_q & a_q[31]}}, a_q};
    assign mul_b = {{32{msgn_q & b_q[31]}}, b_q};
    assign prod  = mul_a * mul_b;

    // One restoring divide step. The remainder stays below the divisor, so the
    // shifted value fits in 33 bits and the kept remainder fits in 32.
    logic [32:0] rem_sh, trial;
    logic        q_bit;
    logic [31:0] rem_nx, quo_nx;
    assign rem_sh = {rem_q, a_q[31]};
    assign trial  = rem_sh - {1'b0, b_q};
    assign q_bit  = ~trial[32];
    assign rem_nx = q_bit ? trial[31:0] : rem_sh[31:0];
    assign quo_nx = {a_q[30:0], q_bit};

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (op_valid && is_mul)      state_d = S_MUL;
                    else if (op_valid && is_div) state_d = (src_b == 32'd0) ? S_DONE : S_DIV;
                end
                S_MUL:  state_d = S_DONE;
                S_DIV:  if (cnt_q == 5'd31) state_d = S_DONE;
                S_DONE: state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    // ---------------- FSM: outputs ----------------
    // Reset also drops stall so the outputs match their reset values even
    // when E is still presenting a divide.
    always_comb begin
        stall = 1'b0;
        if (!flush && !rst) begin
            case (state_q)
                S_IDLE:  stall = op_valid && (is_mul || is_div);
                S_MUL:   stall = 1'b1;
                S_DIV:   stall = 1'b1;
                default: stall = 1'b0;
            endcase
        end
    end

    assign busy    = (state_q != S_IDLE);
    assign hilo_we = we_q & ~flush;
    assign hi_o    = hi_q;
    assign lo_o    = lo_q;

    // ---------------- Datapath next state ----------------
    always_comb begin
        a_d    = a_q;
        b_d    = b_q;
        rem_d  = rem_q;
        cnt_d  = cnt_q;
        msgn_d = msgn_q;
        qneg_d = qneg_q;
        rneg_d = rneg_q;
        hi_d   = hi_q;
        lo_d   = lo_q;
        we_d   = 1'b0;
        // A flush accepts nothing and cancels any write that would be launched.
        if (!flush) begin
            case (state_q)
                S_IDLE: begin
                    if (op_valid) begin
                        case (op)
                            OP_MULT, OP_MULTU: begin
                                a_d    = src_a;
                                b_d    = src_b;
                                msgn_d = op_signed;
                            end
                            OP_DIV, OP_DIVU: begin
                                if (src_b == 32'd0) begin
                                    hi_d = src_a;
                                    lo_d = 32'hFFFF_FFFF;
                                    we_d = 1'b1;
                                end else begin
                                    a_d    = a_abs;
                                    b_d    = b_abs;
                                    rem_d  = 32'd0;
                                    cnt_d  = 5'd0;
                                    qneg_d = a_neg ^ b_neg;
                                    rneg_d = a_neg;
                                end
                            end
                            OP_MTHI: begin
                                hi_d = src_a;
                                lo_d = lo_cur;
                                we_d = 1'b1;
                            end
                            OP_MTLO: begin
                                hi_d = hi_cur;
                                lo_d = src_a;
                                we_d = 1'b1;
                            end
                            default: ;
                        endcase
                    end
                end
                S_MUL: begin
                    hi_d = prod[63:32];
                    lo_d = prod[31:0];
                    we_d = 1'b1;
                end
                S_DIV: begin
                    a_d   = quo_nx;
                    rem_d = rem_nx;
                    cnt_d = cnt_q + 5'd1;
                    if (cnt_q == 5'd31) begin
                        lo_d = qneg_q ? (32'd0 - quo_nx) : quo_nx;
                        hi_d = rneg_q ? (32'd0 - rem_nx) : rem_nx;
                        we_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_q    <= '0;
            b_q    <= '0;
            rem_q  <= '0;
            cnt_q  <= '0;
            msgn_q <= 1'b0;
            qneg_q <= 1'b0;
            rneg_q <= 1'b0;
            hi_q   <= '0;
            lo_q   <= '0;
            we_q   <= 1'b0;
        end else begin
            a_q    <= a_d;
            b_q    <= b_d;
            rem_q  <= rem_d;
            cnt_q  <= cnt_d;
            msgn_q <= msgn_d;
            qneg_q <= qneg_d;
            rneg_q <= rneg_d;
            hi_q   <= hi_d;
            lo_q   <= lo_d;
            we_q   <= we_d;
        end
    end

endmodule

// File: tb/tb_muldiv_hilo_ctrl.sv
// Directed bench for muldiv_hilo_ctrl. Inputs change and outputs are sampled
// 1-2 time units after the rising edge.
module tb_muldiv_hilo_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        op_valid = 1'b0;
    logic [2:0]  op = 3'b000;
    logic [31:0] src_a = '0, src_b = '0, hi_cur = '0, lo_cur = '0;
    logic        flush = 1'b0;
    logic        stall, busy, hilo_we;
    logic [31:0] hi_o, lo_o;

    int checks = 0;
    int errors = 0;

    muldiv_hilo_ctrl dut (
        .clk(clk), .rst(rst), .op_valid(op_valid), .op(op),
        .src_a(src_a), .src_b(src_b), .hi_cur(hi_cur), .lo_cur(lo_cur),
        .flush(flush), .stall(stall), .busy(busy), .hilo_we(hilo_we),
        .hi_o(hi_o), .lo_o(lo_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one op. Count its stall cycles with a bound, then check the write
    // pulse in the first non-stalled cycle and that the pulse lasts one cycle.
    task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] b, input int exp_stalls,
                          input logic [31:0] eh, input logic [31:0] el);
        int   n;
        logic early;
        n = 0;
        early = 1'b0;
        op = o; src_a = a; src_b = b; op_valid = 1'b1;
        #1;
        while (stall && n < 60) begin
            if (hilo_we) early = 1'b1;
            n++;
            tick();
        end
        chk({tag, " stall_cycles"}, n, exp_stalls);
        chk({tag, " early_we"}, {31'd0, early}, 32'd0);
        chk({tag, " we"}, {31'd0, hilo_we}, 32'd1);
        chk({tag, " hi"}, hi_o, eh);
        chk({tag, " lo"}, lo_o, el);
        op_valid = 1'b0;
        tick();
        chk({tag, " we_after"}, {31'd0, hilo_we}, 32'd0);
        chk({tag, " busy_after"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        logic seen;

        // Reset state
        #3;
        chk("rst stall", {31'd0, stall}, 32'd0);
        chk("rst busy", {31'd0, busy}, 32'd0);
        chk("rst we", {31'd0, hilo_we}, 32'd0);
        chk("rst hi", hi_o, 32'd0);
        chk("rst lo", lo_o, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        tick();

        // Multiply
        run_op("mult", 3'b000, 32'hFFFF_FFFF, 32'h0000_0002, 2, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        run_op("multu", 3'b001, 32'hFFFF_FFFF, 32'h0000_0002, 2, 32'h0000_0001, 32'hFFFF_FFFE);
        run_op("mult_neg", 3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 2, 32'hFFFF_FFFF, 32'hFFFF_FFEB);

        // Divide
        run_op("divu_7_2", 3'b011, 32'h0000_0007, 32'h0000_0002, 33, 32'h0000_0001, 32'h0000_0003);
        run_op("div_m7_2", 3'b010, 32'hFFFF_FFF9, 32'h0000_0002, 33, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        run_op("div_7_m2", 3'b010, 32'h0000_0007, 32'hFFFF_FFFE, 33, 32'h0000_0001, 32'hFFFF_FFFD);
        run_op("div_min_m1", 3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'h0000_0000, 32'h8000_0000);
        run_op("divu_big", 3'b011, 32'h8000_0000, 32'h0000_0003, 33, 32'h0000_0002, 32'h2AAA_AAAA);
        run_op("div_by0", 3'b010, 32'h1234_5678, 32'h0000_0000, 1, 32'h1234_5678, 32'hFFFF_FFFF);

        // MTHI followed immediately by MULT
        hi_cur = 32'h0; lo_cur = 32'h1111_1111;
        op = 3'b100; src_a = 32'hA5A5_A5A5; op_valid = 1'b1;
        #1;
        chk("mthi stall", {31'd0, stall}, 32'd0);
        tick();
        chk("mthi we", {31'd0, hilo_we}, 32'd1);
        chk("mthi hi", hi_o, 32'hA5A5_A5A5);
        chk("mthi lo", lo_o, 32'h1111_1111);
        op = 3'b000; src_a = 32'd3; src_b = 32'd5;
        #1;
        chk("mthi_mult stall c1", {31'd0, stall}, 32'd1);
        tick();
        chk("mthi_mult we c2", {31'd0, hilo_we}, 32'd0);
        tick();
        chk("mthi_mult we c3", {31'd0, hilo_we}, 32'd1);
        chk("mthi_mult lo c3", lo_o, 32'd15);
        chk("mthi_mult hi c3", hi_o, 32'd0);
        op_valid = 1'b0;
        tick();

        // MTLO
        hi_cur = 32'h2222_2222;
        op = 3'b101; src_a = 32'h5A5A_5A5A; op_valid = 1'b1;
        #1;
        tick();
        op_valid = 1'b0;
        chk("mtlo we", {31'd0, hilo_we}, 32'd1);
        chk("mtlo hi", hi_o, 32'h2222_2222);
        chk("mtlo lo", lo_o, 32'h5A5A_5A5A);

        // MTHI write cancelled by a flush in its write cycle
        tick();
        op = 3'b100; src_a = 32'hDEAD_BEEF; op_valid = 1'b1;
        #1;
        tick();
        op_valid = 1'b0; flush = 1'b1;
        #1;
        chk("mthi_flush we", {31'd0, hilo_we}, 32'd0);
        tick();
        flush = 1'b0;

        // Reserved op is ignored
        op = 3'b110; src_a = 32'h1; op_valid = 1'b1;
        #1;
        chk("rsvd stall", {31'd0, stall}, 32'd0);
        tick();
        op_valid = 1'b0;
        chk("rsvd we", {31'd0, hilo_we}, 32'd0);
        chk("rsvd busy", {31'd0, busy}, 32'd0);

        // Flush in cycle 10 of a divide
        op = 3'b010; src_a = 32'd100; src_b = 32'd7; op_valid = 1'b1;
        #1;
        for (int i = 0; i < 10; i++) tick();
        flush = 1'b1;
        #1;
        chk("divflush stall", {31'd0, stall}, 32'd0);
        chk("divflush busy", {31'd0, busy}, 32'd1);
        tick();
        flush = 1'b0; op_valid = 1'b0;
        #1;
        chk("divflush idle", {31'd0, busy}, 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (hilo_we) seen = 1'b1;
            tick();
        end
        chk("divflush no_we", {31'd0, seen}, 32'd0);
        run_op("mult_after_flush", 3'b000, 32'h8000_0000, 32'h8000_0000, 2, 32'h4000_0000, 32'h0000_0000);

        // Flush coincident with the DONE cycle
        op = 3'b000; src_a = 32'd3; src_b = 32'd4; op_valid = 1'b1;
        #1;
        tick();
        tick();
        flush = 1'b1;
        #1;
        chk("doneflush we", {31'd0, hilo_we}, 32'd0);
        chk("doneflush stall", {31'd0, stall}, 32'd0);
        tick();
        flush = 1'b0; op_valid = 1'b0;
        #1;
        chk("doneflush we_next", {31'd0, hilo_we}, 32'd0);
        chk("doneflush busy_next", {31'd0, busy}, 32'd0);

        // Asynchronous reset between edges in cycle 5 of a divide
        op = 3'b010; src_a = 32'd100; src_b = 32'd7; op_valid = 1'b1;
        #1;
        for (int i = 0; i < 5; i++) tick();
        #2;
        rst = 1'b1;
        #1;
        chk("midrst busy", {31'd0, busy}, 32'd0);
        chk("midrst stall", {31'd0, stall}, 32'd0);
        chk("midrst we", {31'd0, hilo_we}, 32'd0);
        chk("midrst hi", hi_o, 32'd0);
        chk("midrst lo", lo_o, 32'd0);
        op_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (hilo_we) seen = 1'b1;
        end
        chk("midrst no_we", {31'd0, seen}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
